// File: rtl/router_fsm_nch_pkg.sv
// Shared state encoding and elaboration helpers for the 1xN router ingress controller.
package router_fsm_nch_pkg;

  // Values 0..7 keep the 1x3 controller's encoding; DROP extends it.
  typedef enum logic [3:0] {
    StDecodeAddress    = 4'd0,
    StLoadFirstData    = 4'd1,
    StLoadData         = 4'd2,
    StWaitTillEmpty    = 4'd3,
    StCheckParityError = 4'd4,
    StLoadParity       = 4'd5,
    StFifoFullState    = 4'd6,
    StLoadAfterFull    = 4'd7,
    StDropPacket       = 4'd8
  } router_state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/router_fsm_nch.sv
// Ingress controller for a 1xN packet router: decodes the header address, sequences
// header/payload/parity loads into the chosen FIFO and drops bad or stalled packets.
module router_fsm_nch
  import router_fsm_nch_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic [ADDR_W-1:0] din,
  output logic              wr_en_reg,
  output logic              detect_addr,
  output logic              ld_state,
  output logic              laf_state,
  output logic              lfd_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [ADDR_W-1:0] sel_ch,
  output logic              addr_err,
  output logic              wait_tmo
);

  localparam int unsigned AddrSpan = 2 ** ADDR_W;
  localparam int unsigned CntW     = clog2_min1(WAIT_TIMEOUT + 1);
  localparam logic [ADDR_W:0] NumChW = (ADDR_W + 1)'(NUM_CH);
  localparam logic [CntW-1:0] TmoLast = (WAIT_TIMEOUT == 0) ? '0 : CntW'(WAIT_TIMEOUT - 1);
  localparam logic TmoEnable = (WAIT_TIMEOUT != 0);

  router_state_e     state_q, state_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              addr_err_q, addr_err_d;
  logic              wait_tmo_q, wait_tmo_d;

  logic [AddrSpan-1:0] empty_ext;
  logic [AddrSpan-1:0] srst_ext;
  logic                din_valid;
  logic                sel_srst;
  logic                tmo_hit;

  // Widen per-channel flags to the full address space so any address indexes safely.
  always_comb begin
    empty_ext               = '0;
    empty_ext[NUM_CH-1:0]   = fifo_empty;
    srst_ext                = '0;
    srst_ext[NUM_CH-1:0]    = soft_rst;
  end

  assign din_valid = ({1'b0, din} < NumChW);
  assign sel_srst  = srst_ext[sel_q];
  assign tmo_hit   = TmoEnable && (cnt_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_err_d = 1'b0;
    wait_tmo_d = 1'b0;
    if (sel_srst && (state_q != StDecodeAddress) && (state_q != StDropPacket)) begin
      state_d = StDecodeAddress;
    end else begin
      unique case (state_q)
        StDecodeAddress: begin
          if (pkt_valid) begin
            if (din_valid) begin
              sel_d   = din;
              state_d = empty_ext[din] ? StLoadFirstData : StWaitTillEmpty;
            end else begin
              state_d    = StDropPacket;
              addr_err_d = 1'b1;
            end
          end
        end
        StLoadFirstData: state_d = StLoadData;
        StLoadData: begin
          if (fifo_full)       state_d = StFifoFullState;
          else if (!pkt_valid) state_d = StLoadParity;
        end
        StFifoFullState: begin
          if (!fifo_full) state_d = StLoadAfterFull;
        end
        StLoadAfterFull: begin
          if (parity_done)        state_d = StDecodeAddress;
          else if (low_pkt_valid) state_d = StLoadParity;
          else                    state_d = StLoadData;
        end
        StLoadParity:       state_d = StCheckParityError;
        StCheckParityError: state_d = fifo_full ? StFifoFullState : StDecodeAddress;
        StWaitTillEmpty: begin
          // An emptying FIFO wins over a timeout in the same cycle.
          if (empty_ext[sel_q]) begin
            state_d = StLoadFirstData;
          end else if (tmo_hit) begin
            state_d    = StDropPacket;
            wait_tmo_d = 1'b1;
          end
        end
        StDropPacket: begin
          if (!pkt_valid) state_d = StDecodeAddress;
        end
        default: state_d = StDecodeAddress;
      endcase
    end
  end

  // Counts cycles already spent waiting; saturates when the timeout is disabled.
  always_comb begin
    cnt_d = '0;
    if ((state_q == StWaitTillEmpty) && (state_d == StWaitTillEmpty)) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StDecodeAddress;
      sel_q      <= '0;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
      wait_tmo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      wait_tmo_q <= wait_tmo_d;
    end
  end

  assign detect_addr = (state_q == StDecodeAddress);
  assign lfd_state   = (state_q == StLoadFirstData);
  assign ld_state    = (state_q == StLoadData);
  assign laf_state   = (state_q == StLoadAfterFull);
  assign full_state  = (state_q == StFifoFullState);
  assign rst_int_reg = (state_q == StCheckParityError);
  assign drop_state  = (state_q == StDropPacket);
  assign wr_en_reg   = ld_state || laf_state || (state_q == StLoadParity);
  assign busy        = !(detect_addr || ld_state || drop_state);
  assign sel_ch      = sel_q;
  assign addr_err    = addr_err_q;
  assign wait_tmo    = wait_tmo_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Self-checking bench for router_fsm_nch: directed vector table, multi-cycle corner
// sequences, a 5-channel instance and randomized traffic against a behavioural model.
module tb_router_fsm_nch;

  localparam int NumCh     = 3;
  localparam int TmoCycles = 8;
  localparam int DA = 0, LFD = 1, LD = 2, WTE = 3, CPE = 4, LP = 5, FFS = 6, LAF = 7, DRP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [2:0] fifo_empty, soft_rst;
  logic [1:0] din;
  logic       wr_en_reg, detect_addr, ld_state, laf_state, lfd_state, full_state;
  logic       rst_int_reg, busy, drop_state, addr_err, wait_tmo;
  logic [1:0] sel_ch;
  logic [10:0] obs;

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(TmoCycles)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_rst(soft_rst), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .din(din), .wr_en_reg(wr_en_reg),
    .detect_addr(detect_addr), .ld_state(ld_state), .laf_state(laf_state),
    .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .busy(busy), .drop_state(drop_state), .sel_ch(sel_ch), .addr_err(addr_err),
    .wait_tmo(wait_tmo)
  );
  assign obs = {wr_en_reg, detect_addr, ld_state, laf_state, lfd_state, full_state,
                rst_int_reg, busy, drop_state, addr_err, wait_tmo};

  logic       rst5, pv5, ff5, pd5, lpv5;
  logic [4:0] fe5, sr5;
  logic [2:0] din5, sel5;
  logic       wr5, da5, ld5, laf5, lfd5, full5, cpe5, busy5, drop5, ae5, wt5;
  logic [10:0] obs5;

  router_fsm_nch #(.NUM_CH(5), .ADDR_W(3), .WAIT_TIMEOUT(TmoCycles)) dut5 (
    .clk(clk), .rst(rst5), .pkt_valid(pv5), .fifo_full(ff5), .fifo_empty(fe5),
    .soft_rst(sr5), .parity_done(pd5), .low_pkt_valid(lpv5), .din(din5),
    .wr_en_reg(wr5), .detect_addr(da5), .ld_state(ld5), .laf_state(laf5),
    .lfd_state(lfd5), .full_state(full5), .rst_int_reg(cpe5), .busy(busy5),
    .drop_state(drop5), .sel_ch(sel5), .addr_err(ae5), .wait_tmo(wt5)
  );
  assign obs5 = {wr5, da5, ld5, laf5, lfd5, full5, cpe5, busy5, drop5, ae5, wt5};

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       pv, ff;
    logic [2:0] fe, sr;
    logic       pd, lpv;
    logic [1:0] d;
    int         st;
    logic       ae, wt;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic pv, input logic ff, input logic [2:0] fe,
                              input logic [2:0] sr, input logic pd, input logic lpv,
                              input logic [1:0] d, input int st, input logic ae,
                              input logic wt, input logic [1:0] sel);
    vec_t v;
    v.pv = pv; v.ff = ff; v.fe = fe; v.sr = sr; v.pd = pd; v.lpv = lpv; v.d = d;
    v.st = st; v.ae = ae; v.wt = wt; v.sel = sel;
    return v;
  endfunction

  // Expected Moore flags for a named state, in the same order as obs.
  function automatic logic [10:0] exp_flags(input int s, input logic ae, input logic wt);
    return {(s == LD || s == LP || s == LAF), (s == DA), (s == LD), (s == LAF), (s == LFD),
            (s == FFS), (s == CPE), !(s == DA || s == LD || s == DRP), (s == DRP), ae, wt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    pkt_valid = v.pv; fifo_full = v.ff; fifo_empty = v.fe; soft_rst = v.sr;
    parity_done = v.pd; low_pkt_valid = v.lpv; din = v.d;
    @(posedge clk); #1;
    check({name, " flags"}, 32'(obs), 32'(exp_flags(v.st, v.ae, v.wt)));
    check({name, " sel"}, 32'(sel_ch), 32'(v.sel));
  endtask

  // Behavioural reference: named states, cycles-waited count, rules applied per cycle.
  int         m_st, m_wait;
  logic [1:0] m_sel;
  logic       m_ae, m_wt;

  task automatic model_step();
    int ns;
    ns   = m_st;
    m_ae = 1'b0;
    m_wt = 1'b0;
    if (m_st != DA && m_st != DRP && soft_rst[m_sel]) ns = DA;
    else begin
      case (m_st)
        DA: if (pkt_valid) begin
          if (int'(din) < NumCh) begin
            m_sel = din;
            ns = fifo_empty[din] ? LFD : WTE;
          end else begin
            ns = DRP;
            m_ae = 1'b1;
          end
        end
        LFD: ns = LD;
        LD:  if (fifo_full) ns = FFS; else if (!pkt_valid) ns = LP;
        FFS: if (!fifo_full) ns = LAF;
        LAF: ns = parity_done ? DA : (low_pkt_valid ? LP : LD);
        LP:  ns = CPE;
        CPE: ns = fifo_full ? FFS : DA;
        WTE: if (fifo_empty[m_sel]) ns = LFD;
             else if (m_wait + 1 == TmoCycles) begin ns = DRP; m_wt = 1'b1; end
        DRP: if (!pkt_valid) ns = DA;
        default: ns = DA;
      endcase
    end
    m_wait = (m_st == WTE && ns == WTE) ? m_wait + 1 : 0;
    m_st   = ns;
  endtask

  initial begin
    rst = 1'b1; pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 3'b000; soft_rst = 3'b000;
    parity_done = 1'b0; low_pkt_valid = 1'b0; din = 2'd0;
    rst5 = 1'b1; pv5 = 1'b0; ff5 = 1'b0; fe5 = 5'b0; sr5 = 5'b0; pd5 = 1'b0; lpv5 = 1'b0;
    din5 = 3'd0;
    @(posedge clk); #1;
    check("reset flags", 32'(obs), 32'(exp_flags(DA, 1'b0, 1'b0)));
    check("reset sel", 32'(sel_ch), 32'd0);
    rst = 1'b0; rst5 = 1'b0;

    // pv ff fe sr pd lpv din | state ae wt sel
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LFD, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LD,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LD,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LP,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, CPE, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, DA,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LFD, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LD,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, FFS, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, FFS, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, FFS, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, LAF, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 2'd1, LP,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, CPE, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd1, DA,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd3, DRP, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd3, DRP, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2'd3, DA,  1'b0, 1'b0, 2'd1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, LFD, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 2'd0, LD,  1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 2'd0, LD,  1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 3'b001, 1'b0, 1'b0, 2'd0, DA,  1'b0, 1'b0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LFD, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LD,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, FFS, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LAF, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0, 2'd2, DA,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LFD, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LD,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LP,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, CPE, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, FFS, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LAF, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LD,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LP,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, CPE, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, DA,  1'b0, 1'b0, 2'd2));
    tbl.push_back(mk(1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, DA,  1'b0, 1'b0, 2'd2));
    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Wait timeout: 8 cycles in WTE, then DROP with a one-cycle wait_tmo.
    run_vec("tmo_enter", mk(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, WTE, 1'b0, 1'b0, 2'd2));
    for (int k = 2; k <= TmoCycles; k++)
      run_vec($sformatf("tmo_wait%0d", k),
              mk(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, WTE, 1'b0, 1'b0, 2'd2));
    run_vec("tmo_fire", mk(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, DRP, 1'b0, 1'b1, 2'd2));
    run_vec("tmo_srst", mk(1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 2'd2, DRP, 1'b0, 1'b0, 2'd2));
    run_vec("tmo_exit", mk(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, DA,  1'b0, 1'b0, 2'd2));

    // FIFO empties on the same cycle the timeout would fire: LFD wins.
    run_vec("race_enter", mk(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, WTE, 1'b0, 1'b0, 2'd2));
    for (int k = 2; k <= TmoCycles; k++)
      run_vec($sformatf("race_wait%0d", k),
              mk(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd2, WTE, 1'b0, 1'b0, 2'd2));
    run_vec("race_lfd", mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LFD, 1'b0, 1'b0, 2'd2));
    run_vec("race_ld",  mk(1'b1, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, LD,  1'b0, 1'b0, 2'd2));
    run_vec("race_srst", mk(1'b1, 1'b0, 3'b100, 3'b100, 1'b0, 1'b0, 2'd2, DA, 1'b0, 1'b0, 2'd2));

    // Five-channel instance: addresses 0..4 accepted, 5..7 dropped.
    for (int d = 0; d < 8; d++) begin
      pv5 = 1'b1; din5 = d[2:0]; fe5 = 5'b11111;
      @(posedge clk); #1;
      if (d < 5) begin
        check($sformatf("ch5 din%0d flags", d), 32'(obs5), 32'(exp_flags(LFD, 1'b0, 1'b0)));
        check($sformatf("ch5 din%0d sel", d), 32'(sel5), 32'(d));
        pv5 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
      end else begin
        check($sformatf("ch5 din%0d flags", d), 32'(obs5), 32'(exp_flags(DRP, 1'b1, 1'b0)));
        check($sformatf("ch5 din%0d sel", d), 32'(sel5), 32'd4);
        pv5 = 1'b0;
        @(posedge clk); #1;
      end
      check($sformatf("ch5 din%0d idle", d), 32'(obs5), 32'(exp_flags(DA, 1'b0, 1'b0)));
    end

    // Async reset in the middle of LOAD_DATA takes effect before the next edge.
    pv5 = 1'b1; din5 = 3'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ch5 pre-rst LD", 32'(obs5), 32'(exp_flags(LD, 1'b0, 1'b0)));
    #2 rst5 = 1'b1;
    #1;
    check("ch5 async rst", 32'(obs5), 32'(exp_flags(DA, 1'b0, 1'b0)));
    check("ch5 async rst sel", 32'(sel5), 32'd0);
    @(posedge clk); #1;
    rst5 = 1'b0; pv5 = 1'b0;

    // Randomized traffic on the 3-channel instance against the reference model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_st = DA; m_wait = 0; m_sel = 2'd0; m_ae = 1'b0; m_wt = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      pkt_valid     = ($urandom_range(0, 9) < 8);
      din           = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 9) < 3);
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < NumCh; b++) begin
        fifo_empty[b] = ($urandom_range(0, 4) == 0);
        soft_rst[b]   = ($urandom_range(0, 29) == 0);
      end
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand%0d flags", n), 32'(obs), 32'(exp_flags(m_st, m_ae, m_wt)));
      check($sformatf("rand%0d sel", n), 32'(sel_ch), 32'(m_sel));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
